// File: rtl/modred_scheduler.sv
// Round-robin front end that shares one serial modular-reduction unit
// between NUM_REQ clients and returns tagged results on a valid/ready port.
module modred_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 1024,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_x_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_m_i,
  output logic                     red_start_o,
  output logic [WIDTH-1:0]         red_x_o,
  output logic [WIDTH-1:0]         red_m_o,
  output logic [WIDTH-1:0]         red_m_bl_o,
  input  logic [WIDTH-1:0]         red_result_i,
  input  logic                     red_valid_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [WIDTH-1:0]         rsp_result_o,
  output logic                     rsp_err_o,
  output logic                     busy_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_m;
  logic [WIDTH-1:0]  r_mbl;
  logic [WIDTH-1:0]  r_result;
  logic              r_start;
  logic              r_rsp_valid;
  logic              r_err;
  logic [CW-1:0]     r_cnt;

  logic              w_any;
  logic [ID_W-1:0]   w_gid;
  logic [ID_W-1:0]   w_idx;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_ready;
  logic [WIDTH-1:0]  w_x;
  logic [WIDTH-1:0]  w_m;
  logic [WIDTH-1:0]  w_mbl;

  function automatic logic [ID_W-1:0] f_wrap(
    input logic [ID_W-1:0] p,
    input int              i
  );
    int s;
    s = int'(p) + i;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // smallest k with 2**k >= m, i.e. index of top set bit of (m-1), plus one
  function automatic logic [WIDTH-1:0] f_bitlen(
    input logic [WIDTH-1:0] m
  );
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] k;
    v = m - 1'b1;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) k = WIDTH'(i + 1);
    end
    if (m == '0) k = '0;
    return k;
  endfunction

  // scan downward so the lowest offset from r_ptr wins
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    w_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = f_wrap(r_ptr, i);
      if (req_valid_i[w_idx]) begin
        w_any = 1'b1;
        w_gid = w_idx;
      end
    end
  end

  assign w_ptr_nxt = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : w_gid + 1'b1;
  assign w_x       = req_x_i[w_gid*WIDTH +: WIDTH];
  assign w_m       = req_m_i[w_gid*WIDTH +: WIDTH];
  assign w_mbl     = f_bitlen(w_m);

  always_comb begin
    w_ready = '0;
    if (r_state == IDLE && w_any && !rst_i) w_ready[w_gid] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_x         <= '0;
      r_m         <= '0;
      r_mbl       <= '0;
      r_result    <= '0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ptr <= w_ptr_nxt;
            r_id  <= w_gid;
            if (w_m == '0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_err       <= 1'b1;
              r_result    <= '0;
            end else begin
              r_state <= ISSUE;
              r_start <= 1'b1;
              r_x     <= w_x;
              r_m     <= w_m;
              r_mbl   <= w_mbl;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
        WAIT: begin
          if (red_valid_i) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_err       <= 1'b0;
            r_result    <= red_result_i;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_err       <= 1'b1;
            r_result    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = w_ready;
  assign red_start_o  = r_start;
  assign red_x_o      = r_x;
  assign red_m_o      = r_m;
  assign red_m_bl_o   = r_mbl;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_id_o     = r_id;
  assign rsp_result_o = r_result;
  assign rsp_err_o    = r_err;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_modred_scheduler.sv
// Directed scoreboard bench for modred_scheduler with a behavioural
// reduction unit (programmable latency, can be muted).
module tb_modred_scheduler;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_x_i;
  logic [N*W-1:0] req_m_i;
  logic           red_start_o;
  logic [W-1:0]   red_x_o;
  logic [W-1:0]   red_m_o;
  logic [W-1:0]   red_m_bl_o;
  logic [W-1:0]   red_result_i;
  logic           red_valid_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [1:0]     rsp_id_o;
  logic [W-1:0]   rsp_result_o;
  logic           rsp_err_o;
  logic           busy_o;

  logic [W-1:0] tb_x [N];
  logic [W-1:0] tb_m [N];

  always_comb begin
    req_x_i = '0;
    req_m_i = '0;
    for (int k = 0; k < N; k++) begin
      req_x_i[k*W +: W] = tb_x[k];
      req_m_i[k*W +: W] = tb_m[k];
    end
  end

  modred_scheduler #(
    .NUM_REQ(N),
    .WIDTH  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_x_i     (req_x_i),
    .req_m_i     (req_m_i),
    .red_start_o (red_start_o),
    .red_x_o     (red_x_o),
    .red_m_o     (red_m_o),
    .red_m_bl_o  (red_m_bl_o),
    .red_result_i(red_result_i),
    .red_valid_i (red_valid_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_result_o(rsp_result_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o)
  );

  // behavioural reduction unit
  logic         unit_en  = 1'b1;
  int           unit_lat = 3;
  int           ucnt     = 0;
  logic [W-1:0] ures     = '0;
  logic         m_valid  = 1'b0;
  logic         s_valid  = 1'b0;
  logic [W-1:0] s_res    = '0;
  int           starts   = 0;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (red_start_o && unit_en) begin
      ucnt <= unit_lat;
      ures <= red_x_o % red_m_o;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else if (ucnt == 1) begin
      ucnt    <= 0;
      m_valid <= 1'b1;
    end
    if (red_start_o) starts <= starts + 1;
  end

  assign red_valid_i  = m_valid | s_valid;
  assign red_result_i = s_valid ? s_res : ures;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t te;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic seen;

  function automatic logic [63:0] bl(input logic [63:0] m);
    int          k;
    logic [64:0] p;
    k = 0;
    p = 65'd1;
    while (p < {1'b0, m}) begin
      p = p << 1;
      k++;
    end
    return 64'(k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'(0));
    chk({tag, "_start"}, 64'(red_start_o), 64'(0));
    chk({tag, "_redx"}, red_x_o, 64'(0));
    chk({tag, "_redm"}, red_m_o, 64'(0));
    chk({tag, "_mbl"}, red_m_bl_o, 64'(0));
    chk({tag, "_rspv"}, 64'(rsp_valid_o), 64'(0));
    chk({tag, "_rspid"}, 64'(rsp_id_o), 64'(0));
    chk({tag, "_rspres"}, rsp_result_o, 64'(0));
    chk({tag, "_rsperr"}, 64'(rsp_err_o), 64'(0));
    chk({tag, "_busy"}, 64'(busy_o), 64'(0));
  endtask

  task automatic grant_wait(input int id, input bit push);
    int   n;
    exp_t e;
    n = 0;
    #1;
    while (req_ready_o == '0 && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk("grant", 64'(req_ready_o), 64'(1) << id);
    if (push) begin
      e.id  = id;
      e.err = (tb_m[id] == '0);
      e.res = e.err ? '0 : tb_x[id] % tb_m[id];
      sb.push_back(e);
    end
    tick();
    req_valid_i[id] = 1'b0;
    if (tb_m[id] != '0) begin
      chk("issue_start", 64'(red_start_o), 64'(1));
      chk("issue_x", red_x_o, tb_x[id]);
      chk("issue_m", red_m_o, tb_m[id]);
      chk("issue_mbl", red_m_bl_o, bl(tb_m[id]));
    end else begin
      chk("m0_start", 64'(red_start_o), 64'(0));
      chk("m0_rspv", 64'(rsp_valid_o), 64'(1));
    end
  endtask

  task automatic serve(input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid_o && n < 200) begin
      tick();
      n++;
    end
    chk("rsp_valid", 64'(rsp_valid_o), 64'(1));
    chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_id", 64'(rsp_id_o), 64'(e.id));
      chk("rsp_result", rsp_result_o, e.res);
      chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
      chk("rsp_hold_valid", 64'(rsp_valid_o), 64'(1));
      chk("rsp_no_start", 64'(red_start_o), 64'(0));
      chk("rsp_no_ready", 64'(req_ready_o), 64'(0));
      if (h < hold) tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    for (int k = 0; k < N; k++) begin
      tb_x[k] = '0;
      tb_m[k] = '0;
    end
    tick();
    tick();
    check_idle("rst");
    rst_i = 1'b0;
    tick();
    check_idle("post_rst");

    // single request
    tb_x[0] = 64'h1;
    tb_m[0] = 64'h8000_0001;
    req_valid_i[0] = 1'b1;
    grant_wait(0, 1'b1);
    serve(0);
    chk("t1_starts", 64'(starts), 64'(1));

    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();

    // three simultaneous requesters, then 0 re-requests
    for (int k = 0; k < 3; k++) begin
      tb_m[k] = 64'h21;
      tb_x[k] = 64'h64 + 64'(k);
    end
    req_valid_i = 4'b0111;
    grant_wait(0, 1'b1);
    serve(0);
    req_valid_i[0] = 1'b1;
    grant_wait(1, 1'b1);
    serve(0);
    grant_wait(2, 1'b1);
    serve(0);
    grant_wait(0, 1'b1);
    serve(0);
    chk("t2_starts", 64'(starts), 64'(5));

    // response backpressure with a pending request
    tb_x[1] = 64'h1234;
    tb_m[1] = 64'h100;
    req_valid_i[1] = 1'b1;
    grant_wait(1, 1'b1);
    tb_x[2] = 64'h10;
    tb_m[2] = 64'h7;
    req_valid_i[2] = 1'b1;
    serve(5);
    grant_wait(2, 1'b1);
    serve(0);
    chk("t3_starts", 64'(starts), 64'(7));

    // zero modulus
    tb_x[3] = 64'h55;
    tb_m[3] = 64'h0;
    req_valid_i[3] = 1'b1;
    grant_wait(3, 1'b1);
    serve(0);
    chk("t4_starts", 64'(starts), 64'(7));

    // timeout with a muted unit
    unit_en = 1'b0;
    tb_x[0] = 64'h5;
    tb_m[0] = 64'h3;
    req_valid_i[0] = 1'b1;
    grant_wait(0, 1'b0);
    te.id  = 0;
    te.res = '0;
    te.err = 1'b1;
    sb.push_back(te);
    tick();
    lat = 0;
    while (!rsp_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    chk("t5_latency", 64'(lat), 64'(TO));
    serve(0);
    s_res   = 64'hDEAD;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid_o || busy_o) seen = 1'b1;
      tick();
    end
    chk("t5_spurious", 64'(seen), 64'(0));
    unit_en = 1'b1;
    chk("t5_starts", 64'(starts), 64'(8));

    // reset while waiting on the unit
    unit_lat = 8;
    tb_x[1] = 64'h3A32_E4C4_C7A8_C21B;
    tb_m[1] = 64'h7FFF_FFFF;
    req_valid_i[1] = 1'b1;
    grant_wait(1, 1'b0);
    tick();
    tick();
    chk("t6_busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_idle("t6_rst");
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid_o || busy_o) seen = 1'b1;
      tick();
    end
    chk("t6_late_valid", 64'(seen), 64'(0));
    unit_lat = 3;
    tb_x[0] = 64'h77;
    tb_m[0] = 64'h10;
    tb_x[3] = 64'h9;
    tb_m[3] = 64'h4;
    req_valid_i = 4'b1001;
    grant_wait(0, 1'b1);
    serve(0);
    grant_wait(3, 1'b1);
    serve(0);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    chk("total_starts", 64'(starts), 64'(11));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modred_scheduler.md
Name: modred_scheduler

Overview:
- Shares one serialized shift-add modular-reduction unit (start/valid handshake; operands x, m, m_bl) between NUM_REQ requesters.
- Arbitrates round-robin, latches the granted operands and derives m_bl.
- Pulses the unit's start, waits for its valid, then returns the tagged result over a valid/ready response channel.
- Sits between the reduction clients and the single reduction datapath instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 64, operand/result width
TIMEOUT, 1024, max cycles in WAIT before error response
ID_W, $clog2(NUM_REQ), requester id width (derived)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept (one-hot, one cycle)
req_x_i  in  NUM_REQ*WIDTH  packed dividends, requester k at [k*WIDTH +: WIDTH]
req_m_i  in  NUM_REQ*WIDTH  packed moduli, same packing
red_start_o  out  1  one-cycle start pulse to reduction unit
red_x_o  out  WIDTH  dividend to unit
red_m_o  out  WIDTH  modulus to unit
red_m_bl_o  out  WIDTH  bit length of modulus to unit
red_result_i  in  WIDTH  unit result
red_valid_i  in  1  unit result valid
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_id_o  out  ID_W  requester id of response
rsp_result_o  out  WIDTH  x mod m
rsp_err_o  out  1  error: m==0 or timeout
busy_o  out  1  high in any state but IDLE

Behaviour:
- Reset (rst_i high at a clock edge):
  - State -> IDLE; RR pointer -> 0; timeout counter -> 0.
  - All outputs 0: req_ready_o, red_start_o, red_x/m/m_bl_o, rsp_*, busy_o.
  - Reset mid-operation abandons the job; no response is produced; a late red_valid_i is ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i, grant the first valid index at or after ptr, wrapping.
  - Same cycle: assert req_ready_o[g] combinationally; capture x, m, id=g on the clock edge; ptr <= (g+1) mod NUM_REQ.
  - m==0: go to RESP with rsp_err_o=1, result 0; no start issued.
  - Otherwise go to ISSUE.
- m_bl: computed from the latched m, registered in the transition cycle. Value = smallest k with 2^k >= m ($clog2 semantics). m=1 -> 0, m=0x21 -> 6, m=0x80000001 -> 32, m=0x7FFFFFFF -> 31.
- ISSUE:
  - red_start_o=1 for exactly one cycle; red_x/m/m_bl_o driven from registers.
  - red_x/m/m_bl_o are held stable from ISSUE until WAIT exits.
  - Next state: WAIT; timeout counter cleared.
- WAIT:
  - On red_valid_i: capture red_result_i into rsp_result_o, err=0, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no valid: err=1, result 0, go to RESP.
  - red_valid_i outside WAIT is ignored.
- RESP:
  - rsp_valid_o=1; id/result/err stay stable until rsp_ready_i.
  - On handshake, return to IDLE; the next grant can occur in that IDLE cycle.
  - No new grant or start while in RESP (backpressure holds the unit idle).
- Latency (valid result): request-accept edge -> start pulse 1 cycle later -> rsp_valid_o the cycle after red_valid_i. Minimum 3 cycles plus unit latency.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 jobs.
- At most one job in flight; no queueing.
- Requesters must hold x/m stable while req_valid_i is high and not yet accepted.

Test Plan:
- Single request, requester 0, x=0x1, m=0x80000001 -> red_start_o one pulse, red_m_bl_o=32, rsp_id=0, rsp_result=0x1, rsp_err=0.
- Requesters 0,1,2 all valid from the same cycle, m=0x21, x=0x64/0x65/0x66 -> grants in order 0,1,2; results 0x1/0x2/0x3. Requester 0 re-requesting after its response is served only after 1 and 2.
- rsp_ready_i held low 5 cycles after rsp_valid_o -> rsp_id/result/err stable; red_start_o stays 0; a pending req_valid_i gets no req_ready_o until the handshake.
- Requester 3, m=0 -> rsp_err=1, result 0, red_start_o never asserted.
- Unit model never asserts valid, TIMEOUT=16 -> rsp_err=1 exactly 16 cycles after entering WAIT. A later spurious red_valid_i produces no response.
- rst_i asserted for 1 cycle during WAIT (x=0x3A32E4C4C7A8C21B, m=0x7FFFFFFF) -> all outputs 0 next cycle; the late red_valid_i is ignored. A fresh request afterwards is granted starting from ptr=0.
